// File: rtl/speed_pi_if.sv
// speed_pi_if -- signal bundle between a speed-loop master and speed_pi_ctrl.
//
// Signals:
//   rpm        [31:0] measured speed, unsigned, valid with rpm_valid
//   rpm_valid         one-cycle sample strobe
//   setpoint   [15:0] target speed, unsigned RPM
//   kp, ki     [15:0] unsigned proportional / integral gains
//   enable            controller run enable (level)
//   duty       [9:0]  applied PWM duty
//   pwm               motor drive PWM
//   busy              update in flight
//   sat        [1:0]  {clamped high, clamped low} of the last update
//
// Modports: master drives the commands and observes the results; slave is the
// controller side.
interface speed_pi_if;
    logic [31:0] rpm;
    logic        rpm_valid;
    logic [15:0] setpoint;
    logic [15:0] kp;
    logic [15:0] ki;
    logic        enable;
    logic [9:0]  duty;
    logic        pwm;
    logic        busy;
    logic [1:0]  sat;

    modport master (
        output rpm, rpm_valid, setpoint, kp, ki, enable,
        input  duty, pwm, busy, sat
    );

    modport slave (
        input  rpm, rpm_valid, setpoint, kp, ki, enable,
        output duty, pwm, busy, sat
    );
endinterface

// File: rtl/speed_pi_ctrl.sv
// speed_pi_ctrl -- PI speed controller driving a 10-bit PWM.
//
// Each accepted rpm sample runs through a short pipeline FSM:
//   IDLE -> ERR (error computed and clamped) -> MUL (P and I products)
//        -> SUM (shift, clamp to duty range, integrator update) -> IDLE
// The PWM counter free-runs; the applied duty is only reloaded at the period
// boundary so a period is never cut short or stretched.
//
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  speed_pi_if.slave (rpm/rpm_valid/setpoint/kp/ki/enable in;
//        duty/pwm/busy/sat out)
//
// Parameters:
//   SHIFT    arithmetic right shift applied to P+I
//   INT_LIM  symmetric magnitude limit of the integrator
module speed_pi_ctrl #(
    parameter int SHIFT   = 8,
    parameter int INT_LIM = 1048575
) (
    input  logic       clk,
    input  logic       rst,
    speed_pi_if.slave  bus
);

    // Integrator width: magnitude bits for INT_LIM plus sign.
    localparam int INT_W = $clog2(INT_LIM + 1) + 1;
    localparam int P_W   = 34;                     // 17b gain x 17b error
    localparam int I_W   = INT_W + 17;             // 17b gain x integrator
    localparam int S_W   = ((I_W > P_W) ? I_W : P_W) + 1;
    localparam int IS_W  = ((INT_W > 17) ? INT_W : 17) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR  = 2'd1,
        MUL  = 2'd2,
        SUM  = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [31:0]              rpm_reg;
    logic [15:0]              setpoint_reg;
    logic signed [16:0]       err_reg;
    logic signed [P_W-1:0]    p_reg;
    logic signed [I_W-1:0]    i_reg;
    logic signed [INT_W-1:0]  integ_reg;
    logic [9:0]               duty_cmd_reg;
    logic [9:0]               duty_reg;
    logic [9:0]               cnt_reg;
    logic [1:0]               sat_reg;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!bus.enable) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (bus.rpm_valid) state_next = ERR;
                ERR:     state_next = MUL;
                MUL:     state_next = SUM;
                SUM:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // ---------------- datapath combinational terms ----------------
    logic signed [32:0]      err_wide;
    logic signed [16:0]      err_clamped;
    logic signed [P_W-1:0]   p_next;
    logic signed [I_W-1:0]   i_next;
    logic signed [S_W-1:0]   sum_pi;
    logic signed [S_W-1:0]   u_raw;
    logic                    u_hi;
    logic                    u_lo;
    logic [9:0]              duty_cmd_next;
    logic signed [IS_W-1:0]  integ_sum;
    logic signed [INT_W-1:0] integ_clamped;
    logic                    integ_hold;

    always_comb begin
        // 33-bit signed difference of two zero-extended unsigned values
        err_wide = $signed({17'd0, setpoint_reg}) - $signed({1'b0, rpm_reg});
        if (err_wide > 33'sd65535) begin
            err_clamped = 17'sd65535;
        end else if (err_wide < -33'sd65535) begin
            err_clamped = -17'sd65535;
        end else begin
            err_clamped = err_wide[16:0];
        end

        // Gains are unsigned; prefix a zero so they multiply as signed.
        p_next = P_W'($signed({1'b0, bus.kp})) * P_W'(err_reg);
        i_next = I_W'($signed({1'b0, bus.ki})) * I_W'(integ_reg);

        sum_pi = S_W'(p_reg) + S_W'(i_reg);
        u_raw  = sum_pi >>> SHIFT;
        u_hi   = (u_raw > S_W'(1023));
        u_lo   = u_raw[S_W-1];

        if (u_hi) begin
            duty_cmd_next = 10'd1023;
        end else if (u_lo) begin
            duty_cmd_next = 10'd0;
        end else begin
            duty_cmd_next = u_raw[9:0];
        end

        // Anti-windup: stop integrating further into the clamp direction.
        integ_hold = (u_hi && (err_reg > 17'sd0)) || (u_lo && (err_reg < 17'sd0));

        integ_sum = IS_W'(integ_reg) + IS_W'(err_reg);
        if (integ_sum > IS_W'(INT_LIM)) begin
            integ_clamped = INT_W'(INT_LIM);
        end else if (integ_sum < -IS_W'(INT_LIM)) begin
            integ_clamped = -INT_W'(INT_LIM);
        end else begin
            integ_clamped = integ_sum[INT_W-1:0];
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpm_reg      <= '0;
            setpoint_reg <= '0;
            err_reg      <= '0;
            p_reg        <= '0;
            i_reg        <= '0;
            integ_reg    <= '0;
            duty_cmd_reg <= '0;
            sat_reg      <= '0;
        end else if (!bus.enable) begin
            rpm_reg      <= '0;
            setpoint_reg <= '0;
            err_reg      <= '0;
            p_reg        <= '0;
            i_reg        <= '0;
            integ_reg    <= '0;
            duty_cmd_reg <= '0;
            sat_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Capture the sample so the update is immune to input
                    // changes while it is in flight.
                    if (bus.rpm_valid) begin
                        rpm_reg      <= bus.rpm;
                        setpoint_reg <= bus.setpoint;
                    end
                end
                ERR: begin
                    err_reg <= err_clamped;
                end
                MUL: begin
                    // i uses the integrator from before this update.
                    p_reg <= p_next;
                    i_reg <= i_next;
                end
                SUM: begin
                    duty_cmd_reg <= duty_cmd_next;
                    sat_reg      <= {u_hi, u_lo};
                    if (!integ_hold) begin
                        integ_reg <= integ_clamped;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- PWM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_reg <= '0;
        end else if (!bus.enable) begin
            duty_reg <= '0;
        end else if (cnt_reg == 10'd1023) begin
            duty_reg <= duty_cmd_reg;
        end
    end

    assign bus.pwm  = (cnt_reg < duty_reg);
    assign bus.duty = duty_reg;
    assign bus.busy = (state_reg != IDLE);
    assign bus.sat  = sat_reg;

endmodule
